// File: rtl/cascaded_priority_arbiter_reg.sv
// Registered cascaded priority arbiter.
// Groups of fixed-priority requesters, fixed or round-robin group pick, optional grant hold.
module cascaded_priority_arbiter_reg #(
    parameter int N_REQ    = 8,
    parameter int GRP_SIZE = 4,
    parameter bit GRP_RR   = 1'b0,
    parameter bit HOLD     = 1'b1
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic [N_REQ-1:0]                         req,
    output logic [N_REQ-1:0]                         grant,
    output logic                                     grant_valid,
    output logic [(N_REQ > 1 ? $clog2(N_REQ) : 1)-1:0] grant_idx
);

    localparam int NGRP = N_REQ / GRP_SIZE;
    localparam int IW   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int PW   = (NGRP > 1) ? $clog2(NGRP) : 1;

    // Reject group sizes that do not tile the request vector.
    generate
        if ((GRP_SIZE < 1) || (N_REQ % GRP_SIZE != 0) || (NGRP < 1)) begin : g_bad_cfg
            $error("N_REQ must be a positive multiple of GRP_SIZE");
        end
    endgenerate

    typedef enum logic {
        IDLE,
        GRANTED
    } state_t;

    state_t            state_q, state_d;
    logic [N_REQ-1:0]  grant_q, grant_d;
    logic              valid_q, valid_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [PW-1:0]     rr_ptr_q, rr_ptr_d;

    logic [NGRP-1:0]   grp_any;
    logic              grp_found;
    logic              bit_found;
    int                cand;
    int                sel_grp;
    logic              win_any;
    logic [IW-1:0]     win_idx;
    logic [N_REQ-1:0]  win_onehot;
    logic [PW-1:0]     win_rr_next;
    logic              owner_req;

    // Per-group request summary.
    always_comb begin
        grp_any = '0;
        for (int g = 0; g < NGRP; g++) begin
            grp_any[g] = |req[g*GRP_SIZE +: GRP_SIZE];
        end
    end

    // Group pick: lowest requesting group, or first one scanning from rr_ptr.
    always_comb begin
        grp_found = 1'b0;
        sel_grp   = 0;
        cand      = 0;
        for (int k = 0; k < NGRP; k++) begin
            if (GRP_RR) begin
                cand = (int'(rr_ptr_q) + k) % NGRP;
            end else begin
                cand = k;
            end
            if (!grp_found && grp_any[cand]) begin
                grp_found = 1'b1;
                sel_grp   = cand;
            end
        end
    end

    // In-group pick: lowest set bit of the chosen group.
    always_comb begin
        bit_found   = 1'b0;
        win_idx     = '0;
        win_onehot  = '0;
        win_any     = grp_found;
        win_rr_next = PW'((sel_grp + 1) % NGRP);
        for (int b = 0; b < GRP_SIZE; b++) begin
            if (!bit_found && req[sel_grp*GRP_SIZE + b]) begin
                bit_found = 1'b1;
                win_idx   = IW'(sel_grp*GRP_SIZE + b);
            end
        end
        if (win_any) begin
            win_onehot[win_idx] = 1'b1;
        end
    end

    assign owner_req = req[idx_q];

    // Next-state, grant and round-robin pointer update.
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        valid_d  = valid_q;
        idx_d    = idx_q;
        rr_ptr_d = rr_ptr_q;
        unique case (state_q)
            IDLE: begin
                if (win_any) begin
                    state_d  = GRANTED;
                    grant_d  = win_onehot;
                    valid_d  = 1'b1;
                    idx_d    = win_idx;
                    rr_ptr_d = win_rr_next;
                end
            end
            GRANTED: begin
                if (HOLD && owner_req) begin
                    state_d = GRANTED;
                end else if (win_any) begin
                    state_d = GRANTED;
                    grant_d = win_onehot;
                    valid_d = 1'b1;
                    idx_d   = win_idx;
                    if (win_idx != idx_q) begin
                        rr_ptr_d = win_rr_next;
                    end
                end else begin
                    state_d = IDLE;
                    grant_d = '0;
                    valid_d = 1'b0;
                    idx_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
                valid_d = 1'b0;
                idx_d   = '0;
            end
        endcase
    end

    // State and grant registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            valid_q  <= 1'b0;
            idx_q    <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            valid_q  <= valid_d;
            idx_q    <= idx_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign grant       = grant_q;
    assign grant_valid = valid_q;
    assign grant_idx   = idx_q;

endmodule
